// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU command sequencer
// Contents: FSM state type, ALU flag bit indices, operand/opcode widths,
// packed command entry width {fun, b, a}.
package alu_pkg;

    localparam int FUN_W  = 4;
    localparam int DATA_W = 16;

    // Bit positions inside the 5-bit ALU flag vector
    localparam int CARRY = 0;
    localparam int ARITH = 1;
    localparam int LOGIC = 2;
    localparam int CMP   = 3;
    localparam int SHIFT = 4;
    localparam int FLAG_W = SHIFT + 1;

    localparam int ENTRY_W = FUN_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO holding {fun, b, a} entries
// Ports: CLK, RST (sync, active-high), push/wdata (write side),
// pop/rdata (read side, rdata shows the head), full, empty.
// A push while full and a pop while empty are ignored; a push and pop on
// the same edge leave the occupancy unchanged.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers are AW bits wide, so DEPTH being a power of two makes them
    // wrap modulo DEPTH for free.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - sequences queued commands through an external ALU_16B
// Ports: CLK, RST (sync, active-high); cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_fun
// command input; alu_a/alu_b/alu_fun registered drive to the ALU, alu_out/
// alu_flags its result; rsp_valid/rsp_ready/rsp_data/rsp_flags/rsp_fun result.
// Macro ALU_CMD_SEQ_STATS_EN adds op_count (handshakes, wrapping) and
// busy_cycles (non-IDLE cycles, saturating).
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [3:0]  cmd_fun,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_fun,
    input  logic [15:0] alu_out,
    input  logic [4:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [4:0]  rsp_flags,
    output logic [3:0]  rsp_fun
`ifdef ALU_CMD_SEQ_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic [15:0] busy_cycles
`endif
);

    localparam int CNT_W = 3;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
    logic [FUN_W-1:0]    rsp_fun_q, rsp_fun_d;

    logic [ENTRY_W-1:0]  fifo_rdata;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;

    // cmd_ready depends only on the registered occupancy.
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .wdata ({cmd_fun, cmd_b, cmd_a}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_fun_d   = rsp_fun_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    alu_a_d   = fifo_rdata[DATA_W-1:0];
                    alu_b_d   = fifo_rdata[2*DATA_W-1:DATA_W];
                    alu_fun_d = fifo_rdata[ENTRY_W-1:2*DATA_W];
                    fifo_pop  = 1'b1;
                    cnt_d     = CNT_W'(ALU_LAT);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // ALU_LAT edges of countdown give the ALU its full latency
                // after the operands were registered; the result is taken on
                // the edge that sees zero.
                if (cnt_q == '0) begin
                    rsp_data_d  = alu_out;
                    rsp_flags_d = alu_flags;
                    rsp_fun_d   = alu_fun_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_fun_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_fun_q   <= rsp_fun_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_fun   = rsp_fun_q;

`ifdef ALU_CMD_SEQ_STATS_EN
    logic [15:0] op_count_q;
    logic [15:0] busy_cycles_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_count_q    <= '0;
            busy_cycles_q <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready) op_count_q <= op_count_q + 16'd1;
            if (state_q != ST_IDLE && busy_cycles_q != 16'hFFFF)
                busy_cycles_q <= busy_cycles_q + 16'd1;
        end
    end

    assign op_count    = op_count_q;
    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb/tb_alu_cmd_seq.sv - directed self-checking bench for alu_cmd_seq
module tb_alu_cmd_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a, cmd_b;
    logic [3:0]  cmd_fun;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out;
    logic [4:0]  alu_flags;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic [3:0]  rsp_fun;
`ifdef ALU_CMD_SEQ_STATS_EN
    logic [15:0] op_count, busy_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    alu_cmd_seq #(.DEPTH(4), .ALU_LAT(1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_fun    (cmd_fun),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fun    (alu_fun),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .rsp_fun    (rsp_fun)
`ifdef ALU_CMD_SEQ_STATS_EN
        ,
        .op_count   (op_count),
        .busy_cycles(busy_cycles)
`endif
    );

    // Behavioural ALU_16B stand-in: {flags, result}, one-cycle latency.
    function automatic logic [20:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] f);
        logic [16:0] s;
        logic [15:0] r;
        logic [4:0]  fl;
        s  = '0;
        r  = '0;
        fl = '0;
        case (f)
            4'd0:  begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; fl[0] = s[16]; fl[1] = 1'b1; end
            4'd1:  begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; fl[0] = s[16]; fl[1] = 1'b1; end
            4'd2:  begin r = a * b; fl[1] = 1'b1; end
            4'd3:  begin r = (b == 16'd0) ? 16'd0 : a / b; fl[1] = 1'b1; end
            4'd4:  begin r = a & b; fl[2] = 1'b1; end
            4'd5:  begin r = a | b; fl[2] = 1'b1; end
            4'd6:  begin r = a ^ b; fl[2] = 1'b1; end
            4'd7:  begin r = ~(a & b); fl[2] = 1'b1; end
            4'd8:  begin r = a << b[3:0]; fl[4] = 1'b1; end
            4'd9:  begin r = a >> b[3:0]; fl[4] = 1'b1; end
            4'd10: begin r = $signed(a) >>> b[3:0]; fl[4] = 1'b1; end
            4'd11: begin r = {a[14:0], a[15]}; fl[4] = 1'b1; end
            4'd12: begin r = (a == b) ? 16'd1 : 16'd0; fl[3] = 1'b1; end
            4'd13: begin r = (a > b) ? 16'd1 : 16'd0; fl[3] = 1'b1; end
            4'd14: begin r = (a < b) ? 16'd1 : 16'd0; fl[3] = 1'b1; end
            default: begin r = (a != b) ? 16'd1 : 16'd0; fl[3] = 1'b1; end
        endcase
        return {fl, r};
    endfunction

    always @(posedge CLK) {alu_flags, alu_out} <= alu_model(alu_a, alu_b, alu_fun);

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_fun   = f;
        step;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_fun = '0; rsp_ready = 1'b0;
        step;
        step;
        RST = 1'b0;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if ({alu_a, alu_b, alu_fun} !== 36'd0) begin bad++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_fun}); end
        total++; if ({rsp_data, rsp_flags, rsp_fun} !== 25'd0) begin bad++; $display("FAIL reset_rsp got=%h exp=0", {rsp_data, rsp_flags, rsp_fun}); end
`ifdef ALU_CMD_SEQ_STATS_EN
        total++; if ({op_count, busy_cycles} !== 32'd0) begin bad++; $display("FAIL reset_stats got=%h exp=0", {op_count, busy_cycles}); end
`endif
    endtask

    task automatic test_single_add;
        rsp_ready = 1'b0;
        push_cmd(16'd12, 16'd5, 4'd0);          // edge t
        for (int c = 1; c <= 3; c++) begin
            step;                               // edge t+c
            total++;
            if (rsp_valid !== (c == 3)) begin
                bad++; $display("FAIL single_latency edge=t+%0d got=%b exp=%b", c, rsp_valid, (c == 3));
            end
        end
        total++; if (rsp_data !== 16'd17) begin bad++; $display("FAIL single_data got=%0d exp=17", rsp_data); end
        total++; if (rsp_fun !== 4'd0) begin bad++; $display("FAIL single_fun got=%0d exp=0", rsp_fun); end
        total++; if (rsp_flags !== 5'b00010) begin bad++; $display("FAIL single_flags got=%b exp=00010", rsp_flags); end
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_handshake got=%b exp=0", rsp_valid); end
        total++; if ({alu_a, alu_b, alu_fun} !== {16'd12, 16'd5, 4'd0}) begin
            bad++; $display("FAIL single_alu_hold got=%h exp=%h", {alu_a, alu_b, alu_fun}, {16'd12, 16'd5, 4'd0});
        end
    endtask

    task automatic test_hold_stable;
        int w;
        int extra;
        rsp_ready = 1'b0;
        push_cmd(16'h1234, 16'h00FF, 4'd4);
        w = 0;
        while (rsp_valid !== 1'b1 && w < 20) begin step; w++; end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_timeout got=%b exp=1", rsp_valid); end
        for (int c = 0; c < 10; c++) begin
            step;
            total++;
            if ({rsp_valid, rsp_data, rsp_flags, rsp_fun} !== {1'b1, 16'h0034, 5'b00100, 4'd4}) begin
                bad++; $display("FAIL hold_stable cycle=%0d got=%h exp=%h", c,
                                {rsp_valid, rsp_data, rsp_flags, rsp_fun}, {1'b1, 16'h0034, 5'b00100, 4'd4});
            end
        end
        rsp_ready = 1'b1;
        step;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid === 1'b1) extra++;
            step;
        end
        rsp_ready = 1'b0;
        total++; if (extra != 0) begin bad++; $display("FAIL hold_single_handshake got=%0d exp=0", extra); end
    endtask

    task automatic test_fill;
        int got;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL fill_ready push=%0d got=%b exp=1", i, cmd_ready); end
            push_cmd(16'(i + 1), 16'd1, 4'd0);
        end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b exp=0", cmd_ready); end
        cmd_valid = 1'b1; cmd_a = 16'h0099; cmd_b = 16'd1; cmd_fun = 4'd0;
        for (int c = 0; c < 3; c++) begin
            step;
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL fill_blocked cycle=%0d got=%b exp=0", c, cmd_ready); end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            if (rsp_valid === 1'b1) begin
                total++;
                if (got >= 5 || rsp_data !== 16'(got + 2)) begin
                    bad++; $display("FAIL fill_data idx=%0d got=%0d exp=%0d", got, rsp_data, got + 2);
                end
                got++;
            end
            step;
        end
        rsp_ready = 1'b0;
        total++; if (got != 5) begin bad++; $display("FAIL fill_count got=%0d exp=5", got); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL fill_drained_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_back_to_back;
        int k;
        int got;
        int last_cyc;
        logic acc;
        logic [20:0] exp;
        k = 0; got = 0; last_cyc = 0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
            if (rsp_valid === 1'b1) begin
                exp = alu_model(16'd12, 16'd5, 4'(got));
                total++;
                if ({rsp_fun, rsp_flags, rsp_data} !== {4'(got), exp[20:16], exp[15:0]}) begin
                    bad++; $display("FAIL b2b_rsp idx=%0d got=%h exp=%h", got,
                                    {rsp_fun, rsp_flags, rsp_data}, {4'(got), exp[20:16], exp[15:0]});
                end
                if (got > 0) begin
                    total++;
                    if (cyc - last_cyc != 4) begin
                        bad++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=4", got, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            if (k < 16) begin
                cmd_valid = 1'b1; cmd_a = 16'd12; cmd_b = 16'd5; cmd_fun = 4'(k);
            end else begin
                cmd_valid = 1'b0;
            end
            acc = cmd_valid && cmd_ready;
            step;
            if (acc) k++;
        end
        cmd_valid = 1'b0;
        total++; if (got != 16) begin bad++; $display("FAIL b2b_count got=%0d exp=16", got); end
        step;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int seen;
        rsp_ready = 1'b1;
        push_cmd(16'h0010, 16'd1, 4'd0);
        push_cmd(16'h0020, 16'd1, 4'd0);
        push_cmd(16'h0030, 16'd1, 4'd0);
        RST = 1'b1;
        step;
        RST = 1'b0;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", cmd_ready); end
        total++; if ({rsp_valid, rsp_data, rsp_flags, rsp_fun, alu_a, alu_b, alu_fun} !== 62'd0) begin
            bad++; $display("FAIL rstmid_outputs got=%h exp=0", {rsp_valid, rsp_data, rsp_flags, rsp_fun, alu_a, alu_b, alu_fun});
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            step;
            if (rsp_valid === 1'b1 || alu_a !== 16'd0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_response got=%0d exp=0", seen); end
`ifdef ALU_CMD_SEQ_STATS_EN
        total++; if (op_count !== 16'd0) begin bad++; $display("FAIL rstmid_op_count got=%0d exp=0", op_count); end
`endif
        rsp_ready = 1'b0;
    endtask

`ifdef ALU_CMD_SEQ_STATS_EN
    task automatic test_stats;
        rsp_ready = 1'b1;
        push_cmd(16'd1, 16'd2, 4'd0);
        push_cmd(16'd3, 16'd4, 4'd0);
        push_cmd(16'd5, 16'd6, 4'd0);
        for (int c = 0; c < 30; c++) step;
        rsp_ready = 1'b0;
        total++; if (op_count !== 16'd3) begin bad++; $display("FAIL stats_op_count got=%0d exp=3", op_count); end
        total++; if (busy_cycles !== 16'd9) begin bad++; $display("FAIL stats_busy got=%0d exp=9", busy_cycles); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_add;
        test_hold_stable;
        test_fill;
        test_back_to_back;
        test_reset_mid;
`ifdef ALU_CMD_SEQ_STATS_EN
        test_stats;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
